params_wr: RTL

PARAMS_WR -- requirements
Module: params_wr

---
 rtl/params_pkg.sv | 45 ++++
 rtl/params_wr_mux.sv | 25 ++
 rtl/params_wr.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/params_pkg.sv
// Shared types and constants for the parameter-record BRAM writer.
// Readback states exist only when PARAMS_WR_READBACK_CHECK_EN is defined.
package params_pkg;

  localparam int          NUM_WORDS_DEFAULT = 7;
  localparam logic [31:0] START_CODE        = 32'd1;

  localparam logic [31:0] OFS_HEIGHT  = 32'd0;
  localparam logic [31:0] OFS_WIDTH   = 32'd4;
  localparam logic [31:0] OFS_PXL     = 32'd8;
  localparam logic [31:0] OFS_BITS    = 32'd12;
  localparam logic [31:0] OFS_SUBSETS = 32'd16;
  localparam logic [31:0] OFS_OPT     = 32'd20;
  localparam logic [31:0] OFS_CORR    = 32'd24;

  function automatic logic [2:0] word_idx(
    input logic [31:0] ofs
  );
    return ofs[4:2];
  endfunction

  localparam logic [2:0] IDX_HEIGHT  = word_idx(OFS_HEIGHT);
  localparam logic [2:0] IDX_WIDTH   = word_idx(OFS_WIDTH);
  localparam logic [2:0] IDX_PXL     = word_idx(OFS_PXL);
  localparam logic [2:0] IDX_BITS    = word_idx(OFS_BITS);
  localparam logic [2:0] IDX_SUBSETS = word_idx(OFS_SUBSETS);
  localparam logic [2:0] IDX_OPT     = word_idx(OFS_OPT);
  localparam logic [2:0] IDX_CORR    = word_idx(OFS_CORR);

  typedef enum logic [3:0] {
    IDLE,
    LATCH,
    SETUP,
    WRITE,
    DONE
`ifdef PARAMS_WR_READBACK_CHECK_EN
    ,
    RD_ADDR,
    RD_WAIT1,
    RD_WAIT2,
    RD_CMP
`endif
  } state_t;

endpackage

// File: rtl/params_wr_mux.sv
// Combinational select of one snapshot word by record index.
// Indices follow the word offsets of the stored record.
module params_wr_mux
  import params_pkg::*;
(
  input  logic [6:0][31:0] i_snap,
  input  logic [2:0]       i_idx,
  output logic [31:0]      o_word
);

  always_comb begin
    o_word = '0;
    case (i_idx)
      IDX_HEIGHT:  o_word = i_snap[0];
      IDX_WIDTH:   o_word = i_snap[1];
      IDX_PXL:     o_word = i_snap[2];
      IDX_BITS:    o_word = i_snap[3];
      IDX_SUBSETS: o_word = i_snap[4];
      IDX_OPT:     o_word = i_snap[5];
      IDX_CORR:    o_word = i_snap[6];
      default:     o_word = '0;
    endcase
  end

endmodule

// File: rtl/params_wr.sv
// Writes a 7-word parameter record into BRAM on a start request.
// Optional readback verify: define PARAMS_WR_READBACK_CHECK_EN.
module params_wr
  import params_pkg::*;
#(
  parameter int          NUM_WORDS = NUM_WORDS_DEFAULT,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] param_start,
  input  logic [31:0] height_,
  input  logic [31:0] width_,
  input  logic [31:0] num_of_pxl,
  input  logic [31:0] num_of_bits,
  input  logic [31:0] num_of_subsets,
  input  logic [31:0] optimization_method,
  input  logic [31:0] correlation_routine,
`ifdef PARAMS_WR_READBACK_CHECK_EN
  input  logic [31:0] data_in,
  output logic        param_err,
`endif
  output logic [31:0] addr,
  output logic [31:0] data_out,
  output logic [3:0]  we,
  output logic        ea,
  output logic        param_done
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);

  state_t           r_state;
  state_t           w_nxt;
  logic [31:0]      r_addr;
  logic [2:0]       r_idx;
  logic [6:0][31:0] r_snap;
  logic [31:0]      w_word;
  logic             w_start;
  logic             w_last;

  assign w_start = (param_start == START_CODE);
  assign w_last  = (r_idx == LAST_IDX);

  params_wr_mux u_mux (
    .i_snap (r_snap),
    .i_idx  (r_idx),
    .o_word (w_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_start) w_nxt = LATCH;
      LATCH: w_nxt = SETUP;
      SETUP: w_nxt = WRITE;
      WRITE: begin
        if (!w_last)
          w_nxt = SETUP;
        else
`ifdef PARAMS_WR_READBACK_CHECK_EN
          w_nxt = RD_ADDR;
`else
          w_nxt = DONE;
`endif
      end
      DONE:  if (!w_start) w_nxt = IDLE;
`ifdef PARAMS_WR_READBACK_CHECK_EN
      RD_ADDR:  w_nxt = RD_WAIT1;
      RD_WAIT1: w_nxt = RD_WAIT2;
      RD_WAIT2: w_nxt = RD_CMP;
      RD_CMP:   w_nxt = w_last ? DONE : RD_ADDR;
`endif
      default: w_nxt = IDLE;
    endcase
  end

  // Address and index walk the record twice when readback is on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= BASE_ADDR;
      r_idx  <= '0;
      r_snap <= '0;
    end else begin
      unique case (r_state)
        LATCH: begin
          r_snap[0] <= height_;
          r_snap[1] <= width_;
          r_snap[2] <= num_of_pxl;
          r_snap[3] <= num_of_bits;
          r_snap[4] <= num_of_subsets;
          r_snap[5] <= optimization_method;
          r_snap[6] <= correlation_routine;
          r_addr    <= BASE_ADDR;
          r_idx     <= '0;
        end
        WRITE: begin
          if (!w_last) begin
            r_addr <= r_addr + 32'd4;
            r_idx  <= r_idx + 3'd1;
          end else begin
`ifdef PARAMS_WR_READBACK_CHECK_EN
            r_addr <= BASE_ADDR;
            r_idx  <= '0;
`endif
          end
        end
`ifdef PARAMS_WR_READBACK_CHECK_EN
        RD_CMP: begin
          if (!w_last) begin
            r_addr <= r_addr + 32'd4;
            r_idx  <= r_idx + 3'd1;
          end
        end
`endif
        DONE: if (!w_start) r_addr <= BASE_ADDR;
        default: ;
      endcase
    end
  end

`ifdef PARAMS_WR_READBACK_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err <= 1'b0;
    else if (r_state == LATCH)
      r_err <= 1'b0;
    else if (r_state == RD_CMP && data_in != w_word)
      r_err <= 1'b1;
  end

  assign param_err = r_err;
`endif

  assign addr       = r_addr;
  assign we         = (r_state == WRITE) ? 4'hF : 4'h0;
  assign data_out   = (r_state == SETUP || r_state == WRITE) ? w_word : '0;
  assign param_done = (r_state == DONE);
  assign ea         = 1'b1;

endmodule
